// File: rtl/search_best_tracker_if.sv
// Candidate handshake, score input and result handshake between the search
// controller side and search_best_tracker.
interface search_best_tracker_if #(
    parameter int unsigned IDX_WIDTH   = 16,
    parameter int unsigned SCORE_WIDTH = 8
);
    logic                   start;
    logic [IDX_WIDTH-1:0]   n_cand;
    logic [SCORE_WIDTH-1:0] threshold;
    logic                   cand_valid;
    logic [IDX_WIDTH-1:0]   cand_idx;
    logic                   cand_ready;
    logic [SCORE_WIDTH-1:0] score;
    logic                   busy;
    logic                   res_valid;
    logic                   res_ready;
    logic [SCORE_WIDTH-1:0] best_score;
    logic [IDX_WIDTH-1:0]   best_idx;
    logic [IDX_WIDTH-1:0]   hit_count;

    modport master (
        output start, n_cand, threshold, cand_valid, cand_idx, score, res_ready,
        input  cand_ready, busy, res_valid, best_score, best_idx, hit_count
    );

    modport slave (
        input  start, n_cand, threshold, cand_valid, cand_idx, score, res_ready,
        output cand_ready, busy, res_valid, best_score, best_idx, hit_count
    );
endinterface

// File: rtl/search_best_tracker.sv
// Tracks best score, its candidate index and threshold hits over an N-candidate
// search, aligning issued indices with the pipelined comparison scores.
module search_best_tracker #(
    parameter int unsigned IDX_WIDTH   = 16,
    parameter int unsigned SCORE_WIDTH = 8,
    parameter int unsigned PIPE_LAT    = 3
) (
    input logic                  clk,
    input logic                  rst,
    search_best_tracker_if.slave bus
);
    localparam int unsigned LINE_W = PIPE_LAT * IDX_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   n_lat;
    logic [SCORE_WIDTH-1:0] thr_lat;
    logic [IDX_WIDTH-1:0]   issued;
    logic [IDX_WIDTH-1:0]   received;
    logic [SCORE_WIDTH-1:0] best_score;
    logic [IDX_WIDTH-1:0]   best_idx;
    logic [IDX_WIDTH-1:0]   hit_count;
    logic                   busy;
    logic                   res_valid;
    logic [PIPE_LAT-1:0]    line_vld;
    logic [LINE_W-1:0]      line_idx;

    logic                   cand_ready;
    logic                   accept;
    logic                   emerge;
    logic [IDX_WIDTH-1:0]   emerge_idx;

    assign cand_ready = (state == RUN) && (issued < n_lat);
    assign accept     = bus.cand_valid && cand_ready;
    assign emerge     = (state == RUN) && line_vld[PIPE_LAT-1];
    assign emerge_idx = line_idx[LINE_W-1 -: IDX_WIDTH];

    assign bus.cand_ready = cand_ready;
    assign bus.busy       = busy;
    assign bus.res_valid  = res_valid;
    assign bus.best_score = best_score;
    assign bus.best_idx   = best_idx;
    assign bus.hit_count  = hit_count;

    // Index delay line: shifts every cycle so entries stay aligned with z even when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_vld <= '0;
        end else begin
            line_vld <= PIPE_LAT'({line_vld, accept});
        end
    end

    always_ff @(posedge clk) begin
        line_idx <= LINE_W'({line_idx, bus.cand_idx});
    end

    // Search control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_lat      <= '0;
            thr_lat    <= '0;
            issued     <= '0;
            received   <= '0;
            best_score <= '0;
            best_idx   <= '0;
            hit_count  <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_lat      <= bus.n_cand;
                        thr_lat    <= bus.threshold;
                        issued     <= '0;
                        received   <= '0;
                        best_score <= '0;
                        best_idx   <= '0;
                        hit_count  <= '0;
                        busy       <= 1'b1;
                        if (bus.n_cand == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        issued <= issued + IDX_WIDTH'(1);
                    end
                    if (emerge) begin
                        // Strict greater-than keeps the earliest index on ties.
                        if ((received == '0) || (bus.score > best_score)) begin
                            best_score <= bus.score;
                            best_idx   <= emerge_idx;
                        end
                        if ((bus.score >= thr_lat) && (hit_count != '1)) begin
                            hit_count <= hit_count + IDX_WIDTH'(1);
                        end
                        received <= received + IDX_WIDTH'(1);
                        if ((received + IDX_WIDTH'(1)) == n_lat) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
